// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Holds the op/state enums and the func3 group masks.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } muldiv_state_e;

  localparam int DIV_BIT = 2;

  // Bit i set when func3 == i belongs to the group.
  localparam logic [7:0] SIGNED_A_MASK = 8'b0101_0111;
  localparam logic [7:0] SIGNED_B_MASK = 8'b0101_0011;
  localparam logic [7:0] HIGH_MASK     = 8'b0000_1110;
  localparam logic [7:0] REM_MASK      = 8'b1100_0000;

  function automatic logic isDiv(input logic [2:0] f);
    return f[DIV_BIT];
  endfunction

endpackage

// File: rtl/iterative_muldiv_unit_if.sv
// Request/result handshake bundle for the mul/div unit.
// master = issuing execute stage, slave = the unit.
interface iterative_muldiv_unit_if #(
  parameter int XLEN = 32
);

  logic            startValid;
  logic            startReady;
  logic [2:0]      func3;
  logic [XLEN-1:0] operandA;
  logic [XLEN-1:0] operandB;
  logic [4:0]      rdIn;
  logic            flush;
  logic            resultValid;
  logic            resultReady;
  logic [XLEN-1:0] result;
  logic [4:0]      rdOut;
  logic            stallRequest;

  modport master (
    output startValid, func3, operandA, operandB,
    output rdIn, flush, resultReady,
    input  startReady, resultValid, result,
    input  rdOut, stallRequest
  );

  modport slave (
    input  startValid, func3, operandA, operandB,
    input  rdIn, flush, resultReady,
    output startReady, resultValid, result,
    output rdOut, stallRequest
  );

endinterface

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result sign,
// divide-by-zero / signed-overflow detection and their fixed results.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] opA,
  input  logic [XLEN-1:0] opB,
  output logic [XLEN-1:0] absA,
  output logic [XLEN-1:0] absB,
  output logic            negRes,
  output logic            special,
  output logic [XLEN-1:0] specialRes
);

  localparam logic [XLEN-1:0] MIN_VAL =
    {1'b1, {(XLEN-1){1'b0}}};

  logic sA;
  logic sB;
  logic divZero;
  logic divOvf;

  // Sign strip, sign bookkeeping and special-case results
  always_comb begin
    sA = SIGNED_A_MASK[func3] & opA[XLEN-1];
    sB = SIGNED_B_MASK[func3] & opB[XLEN-1];
    absA = sA ? -opA : opA;
    absB = sB ? -opB : opB;
    negRes = REM_MASK[func3] ? sA : (sA ^ sB);
    divZero = isDiv(func3) && (opB == '0);
    divOvf = isDiv(func3) && SIGNED_B_MASK[func3]
             && (opA == MIN_VAL) && (opB == '1);
    special = divZero || divOvf;
    specialRes = '0;
    if (divZero) begin
      specialRes = REM_MASK[func3] ? opA : '1;
    end else if (divOvf) begin
      specialRes = REM_MASK[func3] ? '0 : MIN_VAL;
    end
  end

endmodule

// File: rtl/iterative_muldiv_unit.sv
// Bit-serial RV32M/RV64M multiply/divide unit for the execute stage.
// Optional MULDIV_EARLY_OUT_EN: data-dependent early ITER termination.
module iterative_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic clock,
  input logic reset,
  iterative_muldiv_unit_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam int W2 = 2 * XLEN;

  muldiv_state_e stateQ;
  muldiv_state_e stateD;

  logic [2:0]      opQ;
  logic [XLEN-1:0] aQ;
  logic [XLEN-1:0] bQ;
  logic [4:0]      rdQ;
  logic [W2-1:0]   accQ;
  logic [W2-1:0]   mcandQ;
  logic [XLEN-1:0] quotQ;
  logic [CNT_W-1:0] cntQ;
  logic            negQ;
  logic            specialQ;
  logic [XLEN-1:0] specResQ;
  logic [XLEN-1:0] resultQ;
  logic            validQ;

  logic            accept;
  logic            skipIter;
  logic            lastStep;
  logic [XLEN-1:0] absA;
  logic [XLEN-1:0] absB;
  logic [XLEN-1:0] specRes;
  logic            negRes;
  logic            special;
  logic [XLEN:0]   remTrial;
  logic [XLEN:0]   remDiff;
  logic            qBit;
  logic [W2-1:0]   prodN;
  logic [XLEN-1:0] quotN;
  logic [XLEN-1:0] remN;
  logic [XLEN-1:0] fixRes;

  assign bus.startReady = (stateQ == IDLE);
  assign bus.stallRequest = (stateQ != IDLE);
  assign bus.resultValid = validQ;
  assign bus.result = resultQ;
  assign bus.rdOut = rdQ;

  assign accept = (stateQ == IDLE) && bus.startValid
                  && !bus.flush;

  muldiv_operand_prep #(
    .XLEN(XLEN)
  ) prep (
    .func3(opQ),
    .opA(aQ),
    .opB(bQ),
    .absA(absA),
    .absB(absB),
    .negRes(negRes),
    .special(special),
    .specialRes(specRes)
  );

`ifdef MULDIV_EARLY_OUT_EN
  logic [CNT_W-1:0] lzc;
  logic seenOne;

  // Leading zeros of |dividend|: those quotient bits are known zero
  always_comb begin
    lzc = '0;
    seenOne = 1'b0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      seenOne = seenOne | absA[i];
      if (!seenOne) lzc = lzc + CNT_W'(1);
    end
  end

  assign skipIter = special
    || (isDiv(opQ) ? (absA == '0) : (absB == '0));
  assign lastStep = isDiv(opQ)
    ? (cntQ == CNT_W'(1))
    : (quotQ[XLEN-1:1] == '0);
`else
  assign skipIter = special;
  assign lastStep = (cntQ == CNT_W'(1));
`endif

  // One restoring-division step on the shared registers
  assign remTrial = {accQ[XLEN-1:0], quotQ[XLEN-1]};
  assign remDiff = remTrial - {1'b0, mcandQ[XLEN-1:0]};
  assign qBit = !remDiff[XLEN];

  // Sign fix-up and result-half selection
  always_comb begin
    prodN = negQ ? -accQ : accQ;
    quotN = negQ ? -quotQ : quotQ;
    remN = negQ ? -accQ[XLEN-1:0] : accQ[XLEN-1:0];
    fixRes = prodN[XLEN-1:0];
    if (specialQ) begin
      fixRes = specResQ;
    end else if (REM_MASK[opQ]) begin
      fixRes = remN;
    end else if (isDiv(opQ)) begin
      fixRes = quotN;
    end else if (HIGH_MASK[opQ]) begin
      fixRes = prodN[W2-1:XLEN];
    end
  end

  // Next-state logic; flush wins from any state
  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: if (accept) stateD = PREP;
      PREP: stateD = skipIter ? FIX : ITER;
      ITER: if (lastStep) stateD = FIX;
      FIX:  stateD = DONE;
      DONE: if (validQ && bus.resultReady) stateD = IDLE;
      default: stateD = IDLE;
    endcase
    if (bus.flush) stateD = IDLE;
  end

  // State register and iterative datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= IDLE;
      opQ <= '0;
      aQ <= '0;
      bQ <= '0;
      rdQ <= '0;
      accQ <= '0;
      mcandQ <= '0;
      quotQ <= '0;
      cntQ <= '0;
      negQ <= 1'b0;
      specialQ <= 1'b0;
      specResQ <= '0;
      resultQ <= '0;
      validQ <= 1'b0;
    end else begin
      stateQ <= stateD;
      case (stateQ)
        IDLE: begin
          if (accept) begin
            opQ <= bus.func3;
            aQ <= bus.operandA;
            bQ <= bus.operandB;
            rdQ <= bus.rdIn;
          end
        end
        PREP: begin
          accQ <= '0;
          negQ <= negRes;
          specialQ <= special;
          specResQ <= specRes;
          cntQ <= CNT_W'(XLEN);
          if (isDiv(opQ)) begin
            mcandQ <= {{XLEN{1'b0}}, absB};
`ifdef MULDIV_EARLY_OUT_EN
            quotQ <= absA << lzc;
            cntQ <= CNT_W'(XLEN) - lzc;
`else
            quotQ <= absA;
`endif
          end else begin
            mcandQ <= {{XLEN{1'b0}}, absA};
            quotQ <= absB;
          end
        end
        ITER: begin
          cntQ <= cntQ - CNT_W'(1);
          if (isDiv(opQ)) begin
            accQ <= {{XLEN{1'b0}},
                     qBit ? remDiff[XLEN-1:0]
                          : remTrial[XLEN-1:0]};
            quotQ <= {quotQ[XLEN-2:0], qBit};
          end else begin
            if (quotQ[0]) accQ <= accQ + mcandQ;
            mcandQ <= mcandQ << 1;
            quotQ <= quotQ >> 1;
          end
        end
        FIX: resultQ <= fixRes;
        DONE: begin
          if (!validQ) begin
            validQ <= 1'b1;
          end else if (bus.resultReady) begin
            validQ <= 1'b0;
          end
        end
        default: ;
      endcase
      if (bus.flush) validQ <= 1'b0;
    end
  end

endmodule

// File: tb/tb_iterative_muldiv_unit.sv
// Self-checking bench for iterative_muldiv_unit (XLEN=32, default build).
// Arithmetic/timing model plus directed vectors with literal results.
module tb_iterative_muldiv_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iterative_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  iterative_muldiv_unit #(
    .XLEN(XLEN)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  int nChecks = 0;
  int nFails = 0;
  int cyc = 0;
  bit chkOn = 1'b0;
  bit pending = 1'b0;
  int due = 0;
  logic [31:0] expRes = '0;
  logic [4:0] expRd = '0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic [63:0] ua;
    logic [63:0] ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    r = '0;
    case (f)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      default: begin
        if (b == 32'd0) begin
          r = (f == 3'd4 || f == 3'd5) ? 32'hFFFF_FFFF : a;
        end else if ((f == 3'd4 || f == 3'd6) && a == MINV
                     && b == 32'hFFFF_FFFF) begin
          r = (f == 3'd4) ? MINV : 32'd0;
        end else begin
          case (f)
            3'd4: begin p = sa / sb; r = p[31:0]; end
            3'd5: r = a / b;
            3'd6: begin p = sa % sb; r = p[31:0]; end
            default: r = a % b;
          endcase
        end
      end
    endcase
    return r;
  endfunction

  function automatic int latency(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    bit sp;
    sp = f[2] && (b == 32'd0 || ((f == 3'd4 || f == 3'd6)
         && a == MINV && b == 32'hFFFF_FFFF));
    return sp ? 3 : XLEN + 3;
  endfunction

  // Transaction-level model: busy window, due cycle, expected payload
  always @(posedge clk) begin
    if (rst) begin
      pending = 1'b0;
    end else if (pending && bus.flush) begin
      pending = 1'b0;
    end else if (pending && cyc >= due && bus.resultReady) begin
      pending = 1'b0;
    end else if (!pending && bus.startValid && !bus.flush) begin
      pending = 1'b1;
      due = cyc + 1 + latency(bus.func3, bus.operandA,
                              bus.operandB);
      expRes = model(bus.func3, bus.operandA, bus.operandB);
      expRd = bus.rdIn;
    end
    cyc++;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chkOn) begin
      check("startReady", 64'(bus.startReady), 64'(!pending));
      check("stallRequest", 64'(bus.stallRequest), 64'(pending));
      check("resultValid", 64'(bus.resultValid),
            64'(pending && cyc >= due));
      if (pending && cyc >= due) begin
        check("result", 64'(bus.result), 64'(expRes));
        check("rdOut", 64'(bus.rdOut), 64'(expRd));
      end
    end
  end

  task automatic doOp(input string name, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd,
                      input logic [31:0] expLit,
                      input int expLat, input int hold);
    int k;
    check({name, "_model"}, 64'(model(f, a, b)), 64'(expLit));
    @(negedge clk);
    bus.startValid = 1'b1;
    bus.func3 = f;
    bus.operandA = a;
    bus.operandB = b;
    bus.rdIn = rd;
    bus.resultReady = (hold == 0);
    @(negedge clk);
    bus.startValid = 1'b0;
    bus.operandA = $urandom;
    bus.operandB = $urandom;
    bus.func3 = 3'($urandom);
    bus.rdIn = 5'($urandom);
    k = 0;
    while (bus.resultValid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 64'(k), 64'(expLat));
    check({name, "_result"}, 64'(bus.result), 64'(expLit));
    check({name, "_rd"}, 64'(bus.rdOut), 64'(rd));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_result"}, 64'(bus.result),
            64'(expLit));
      check({name, "_hold_rd"}, 64'(bus.rdOut), 64'(rd));
      check({name, "_hold_stall"}, 64'(bus.stallRequest), 64'd1);
    end
    bus.resultReady = 1'b1;
    @(negedge clk);
    check({name, "_released"}, 64'(bus.stallRequest), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.startValid = 1'b0;
    bus.func3 = '0;
    bus.operandA = '0;
    bus.operandB = '0;
    bus.rdIn = '0;
    bus.flush = 1'b0;
    bus.resultReady = 1'b1;
    repeat (3) @(negedge clk);
    chkOn = 1'b1;
    check("rst_valid", 64'(bus.resultValid), 64'd0);
    check("rst_result", 64'(bus.result), 64'd0);
    check("rst_rd", 64'(bus.rdOut), 64'd0);
    check("rst_stall", 64'(bus.stallRequest), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.startReady), 64'd1);

    doOp("mul_7x6", 3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 35, 0);
    doOp("mul_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 5'd3,
         32'hFFFF_FFF1, 35, 0);
    doOp("mulh_min", 3'd1, MINV, MINV, 5'd7,
         32'h4000_0000, 35, 0);
    doOp("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,
         32'hFFFF_FFFE, 35, 0);
    doOp("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5'd9,
         32'hFFFF_FFFF, 35, 0);
    doOp("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10,
         32'hFFFF_FFFD, 35, 0);
    doOp("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11,
         32'hFFFF_FFFF, 35, 0);
    doOp("div_7_m2", 3'd4, 32'd7, 32'hFFFF_FFFE, 5'd12,
         32'hFFFF_FFFD, 35, 0);
    doOp("rem_7_m2", 3'd6, 32'd7, 32'hFFFF_FFFE, 5'd13,
         32'd1, 35, 0);
    doOp("divu_max_3", 3'd5, 32'hFFFF_FFFF, 32'd3, 5'd14,
         32'h5555_5555, 35, 0);
    doOp("remu_max_7", 3'd7, 32'hFFFF_FFFF, 32'd7, 5'd15,
         32'd3, 35, 0);
    doOp("divu_by0", 3'd5, 32'd100, 32'd0, 5'd16,
         32'hFFFF_FFFF, 3, 0);
    doOp("remu_by0", 3'd7, 32'd100, 32'd0, 5'd17, 32'd100, 3, 0);
    doOp("rem_by0", 3'd6, 32'hFFFF_FFFB, 32'd0, 5'd18,
         32'hFFFF_FFFB, 3, 0);
    doOp("div_ovf", 3'd4, MINV, 32'hFFFF_FFFF, 5'd19, MINV, 3, 0);
    doOp("rem_ovf", 3'd6, MINV, 32'hFFFF_FFFF, 5'd20, 32'd0, 3, 0);
    doOp("hold_mul", 3'd0, 32'd1234, 32'd1000, 5'd21,
         32'd1234000, 35, 20);

    // Flush during ITER: result must never appear
    @(negedge clk);
    bus.startValid = 1'b1;
    bus.func3 = 3'd0;
    bus.operandA = 32'd9;
    bus.operandB = 32'd9;
    bus.rdIn = 5'd22;
    @(negedge clk);
    bus.startValid = 1'b0;
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_ready", 64'(bus.startReady), 64'd1);
    check("flush_stall", 64'(bus.stallRequest), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("flush_novalid", 64'(bus.resultValid), 64'd0);
    end

    // Flush coinciding with a request in IDLE: not accepted
    bus.startValid = 1'b1;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.startValid = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_stall", 64'(bus.stallRequest), 64'd0);
    doOp("after_flush", 3'd0, 32'd11, 32'd3, 5'd23, 32'd33, 35, 0);

    // Reset in the middle of ITER
    @(negedge clk);
    bus.startValid = 1'b1;
    bus.func3 = 3'd5;
    bus.operandA = 32'd1000;
    bus.operandB = 32'd7;
    bus.rdIn = 5'd24;
    @(negedge clk);
    bus.startValid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", 64'(bus.resultValid), 64'd0);
    check("midrst_result", 64'(bus.result), 64'd0);
    check("midrst_rd", 64'(bus.rdOut), 64'd0);
    check("midrst_stall", 64'(bus.stallRequest), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    doOp("after_rst", 3'd5, 32'd1000, 32'd7, 5'd25,
         32'd142, 35, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
